cache_arbiter: RTL and testbench
================================

# cache_arbiter

Shares the single physical-memory (cacheline adaptor) port between the I-cache and D-cache miss paths of the pipelined CPU. Accepts line-fill and writeback requests from both caches, grants one at a time with round-robin tie-breaking, holds the grant until memory responds, and routes the response back to the owner. Sits between the two caches and the cacheline adaptor, below the datapath's `icache_*` / `dcache_*` interfaces.

## Interface
- `LINE_W`, default 256: cacheline width in bits.
- `ADDR_W`, default 32: line address width.
- `clk` input, 1 bit: clock; all state changes on the rising edge.
- `rst` input, 1 bit: asynchronous, active-low reset.
- `i_read` input, 1 bit: I-cache line-fill request.
- `i_address` input, `ADDR_W`: I-cache line address.
- `i_rdata` output, `LINE_W`: fill data returned to the I-cache.
- `i_resp` output, 1 bit: I-cache transaction complete.
- `d_read` input, 1 bit: D-cache line-fill request.
- `d_write` input, 1 bit: D-cache writeback request.
- `d_address` input, `ADDR_W`: D-cache line address.
- `d_wdata` input, `LINE_W`: D-cache writeback data.
- `d_rdata` output, `LINE_W`: fill data returned to the D-cache.
- `d_resp` output, 1 bit: D-cache transaction complete.
- `mem_read` output, 1 bit: memory read strobe.
- `mem_write` output, 1 bit: memory write strobe.
- `mem_address` output, `ADDR_W`: memory line address.
- `mem_wdata` output, `LINE_W`: memory write data.
- `mem_rdata` input, `LINE_W`: memory read data.
- `mem_resp` input, 1 bit: memory transaction complete.

## Operation
- States: IDLE, SERVE_I, SERVE_D, RECOVER.
- **IDLE**
  - Sample `i_req = i_read` and `d_req = d_read | d_write`.
  - Only one request pending: go to that requester's SERVE state.
  - Both pending: grant the requester not granted last (`last_grant` flag). Then update `last_grant`.
  - No request pending: stay in IDLE.
- **At grant**, latch into internal registers:
  - address;
  - write data (D only);
  - op: write if `d_write`, else read. If `d_read` and `d_write` are both high, write takes precedence.
- **SERVE_I**
  - `mem_read` = 1, `mem_write` = 0, `mem_address` = latched address.
  - On `mem_resp`: `i_resp` = 1 combinationally, `i_rdata` = `mem_rdata`, next state RECOVER.
- **SERVE_D**
  - `mem_read` or `mem_write` per latched op; `mem_address` and `mem_wdata` from latches.
  - On `mem_resp`: `d_resp` = 1, `d_rdata` = `mem_rdata`, next state RECOVER.
- **RECOVER**
  - All strobes low for one cycle so the served cache can drop its request; no new grant this cycle.
  - Next state IDLE unconditionally.
- **Outputs outside these conditions**
  - `i_resp` / `d_resp` are 0 except as above. They never assert for the non-owner, even if `mem_resp` arrives then.
  - `i_rdata` and `d_rdata` are both driven `mem_rdata` at all times; only the `resp` signals qualify them.
  - `mem_wdata` is the latched data, 0 after reset.
- **Counters**: 16-bit saturating `i_wait_cnt` and `d_wait_cnt`, internal and visible to the bench hierarchically.
  - Each increments every cycle its requester is pending and not in its own SERVE state.
  - Each clears when that requester is granted.
- **Spurious response**: `mem_resp` in IDLE or RECOVER is ignored.

## Timing
- **Reset** (`rst` low, asynchronous):
  - State is IDLE; all outputs are 0 (`i_rdata`/`d_rdata` follow `mem_rdata`).
  - `last_grant` = D, so the I-cache wins the first tie.
  - Latches and counters are 0.
- **Reset mid-transaction**: strobes drop immediately. No `resp` is issued for the aborted transaction.
- **Grant latency**: request high in IDLE at edge N gives the strobe high from cycle N+1. Strobes are Moore outputs, decoded from state only.
- **Response**: `mem_resp` in cycle M gives `resp` in cycle M (same cycle), RECOVER at M+1, IDLE at M+2. The earliest next grant's strobe is at M+3.
- **Minimum transaction**: a 1-cycle memory latency occupies 3 cycles.
- **Address stability**: a requester changing its address after grant has no effect on the in-flight transaction.
- **Back-to-back alternation**: with both requesters continuously pending, grants strictly alternate I, D, I, D.

## Test plan
- **Reset**: hold `rst`=0 with `i_read`=1 → all strobes 0, no `resp`. Release → `mem_read`=1 with `mem_address`=`i_address` one cycle later.
- **Tie**: `i_read`=1 (addr 0x1000) and `d_write`=1 (addr 0x2000, wdata 0xA5…A5) in the same cycle; memory latency 4 → I served first (`i_resp` in cycle 5). Then `mem_write`=1, `mem_address`=0x2000 at cycle 8, `d_resp` 4 cycles later.
- **Fairness**: both requests held continuously for 6 transactions → grant order I, D, I, D, I, D. Neither wait counter exceeds one transaction time plus 2.
- **Ownership**: `mem_resp` pulsed in IDLE, and during SERVE_D → `i_resp` never asserts. A stray pulse in IDLE causes no state change.
- **Address change**: `d_read` at 0x3000, address changed to 0x4000 mid-transaction → `mem_address` stays 0x3000 until `d_resp`.
- **Abort**: `rst` low during SERVE_D → `mem_read`/`mem_write` drop the same cycle; after release, the pending `i_read` is granted normally.

Source files
------------

// File: rtl/cache_arbiter.sv
// rtl/cache_arbiter.sv - round-robin arbiter sharing one memory port between I-cache and D-cache
//
// Purpose: grants the single cacheline-adaptor port to either the I-cache fill
// path or the D-cache fill/writeback path, one transaction at a time, holding
// the grant until mem_resp and then inserting one idle RECOVER cycle.
//
// Ports:
//   clk, rst                 clock, asynchronous active-low reset
//   i_read, i_address        I-cache fill request and line address
//   i_rdata, i_resp          fill data (always mem_rdata) and completion to I-cache
//   d_read, d_write          D-cache fill / writeback requests
//   d_address, d_wdata       D-cache line address and writeback data
//   d_rdata, d_resp          fill data (always mem_rdata) and completion to D-cache
//   mem_read, mem_write      memory strobes (decoded from state only)
//   mem_address, mem_wdata   latched address / write data of the granted request
//   mem_rdata, mem_resp      memory read data and completion
module cache_arbiter #(
    parameter int LINE_W = 256,
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_read,
    input  logic [ADDR_W-1:0] i_address,
    output logic [LINE_W-1:0] i_rdata,
    output logic              i_resp,
    input  logic              d_read,
    input  logic              d_write,
    input  logic [ADDR_W-1:0] d_address,
    input  logic [LINE_W-1:0] d_wdata,
    output logic [LINE_W-1:0] d_rdata,
    output logic              d_resp,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_address,
    output logic [LINE_W-1:0] mem_wdata,
    input  logic [LINE_W-1:0] mem_rdata,
    input  logic              mem_resp
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SERVE_I = 2'd1,
        SERVE_D = 2'd2,
        RECOVER = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic              last_grant_q, last_grant_d;   // 1: D was granted most recently
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [LINE_W-1:0] wdata_q, wdata_d;
    logic              write_q, write_d;
    // Wait counters keep their plain names so they can be probed hierarchically.
    logic [15:0]       i_wait_cnt, i_wait_cnt_d;
    logic [15:0]       d_wait_cnt, d_wait_cnt_d;

    logic              i_req, d_req;
    logic              grant_i, grant_d;

    // State register and datapath latches.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            addr_q       <= '0;
            wdata_q      <= '0;
            write_q      <= 1'b0;
            i_wait_cnt   <= '0;
            d_wait_cnt   <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            write_q      <= write_d;
            i_wait_cnt   <= i_wait_cnt_d;
            d_wait_cnt   <= d_wait_cnt_d;
        end
    end

    // Grant decision: only in IDLE; on a tie the side not granted last wins.
    always_comb begin
        i_req   = i_read;
        d_req   = d_read | d_write;
        grant_i = 1'b0;
        grant_d = 1'b0;
        if (state_q == IDLE) begin
            if (i_req && d_req) begin
                grant_i = last_grant_q;
                grant_d = ~last_grant_q;
            end else begin
                grant_i = i_req;
                grant_d = d_req;
            end
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (grant_i) begin
                    state_d = SERVE_I;
                end else if (grant_d) begin
                    state_d = SERVE_D;
                end
            end
            SERVE_I: if (mem_resp) state_d = RECOVER;
            SERVE_D: if (mem_resp) state_d = RECOVER;
            RECOVER: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Latches captured at grant time, plus the saturating wait counters.
    always_comb begin
        last_grant_d = last_grant_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        write_d      = write_q;
        if (grant_i) begin
            addr_d       = i_address;
            write_d      = 1'b0;
            last_grant_d = 1'b0;
        end
        if (grant_d) begin
            addr_d       = d_address;
            wdata_d      = d_wdata;
            write_d      = d_write;          // writeback wins when both are raised
            last_grant_d = 1'b1;
        end

        i_wait_cnt_d = i_wait_cnt;
        if (grant_i) begin
            i_wait_cnt_d = '0;
        end else if (i_req && (state_q != SERVE_I) && (i_wait_cnt != 16'hFFFF)) begin
            i_wait_cnt_d = i_wait_cnt + 16'd1;
        end

        d_wait_cnt_d = d_wait_cnt;
        if (grant_d) begin
            d_wait_cnt_d = '0;
        end else if (d_req && (state_q != SERVE_D) && (d_wait_cnt != 16'hFFFF)) begin
            d_wait_cnt_d = d_wait_cnt + 16'd1;
        end
    end

    // Outputs: strobes are Moore; resp is gated by ownership so a stray
    // mem_resp in IDLE/RECOVER or for the other side never leaks through.
    always_comb begin
        mem_read    = (state_q == SERVE_I) || ((state_q == SERVE_D) && !write_q);
        mem_write   = (state_q == SERVE_D) && write_q;
        mem_address = addr_q;
        mem_wdata   = wdata_q;
        i_resp      = (state_q == SERVE_I) && mem_resp;
        d_resp      = (state_q == SERVE_D) && mem_resp;
        i_rdata     = mem_rdata;
        d_rdata     = mem_rdata;
    end

endmodule

// File: tb/tb_cache_arbiter.sv
// tb/tb_cache_arbiter.sv - self-checking bench for cache_arbiter
module tb_cache_arbiter;

    localparam int LW = 256;
    localparam int AW = 32;
    localparam int LAT = 3;

    logic          clk;
    logic          rst;
    logic          i_read;
    logic [AW-1:0] i_address;
    logic [LW-1:0] i_rdata;
    logic          i_resp;
    logic          d_read;
    logic          d_write;
    logic [AW-1:0] d_address;
    logic [LW-1:0] d_wdata;
    logic [LW-1:0] d_rdata;
    logic          d_resp;
    logic          mem_read;
    logic          mem_write;
    logic [AW-1:0] mem_address;
    logic [LW-1:0] mem_wdata;
    logic [LW-1:0] mem_rdata;
    logic          mem_resp;

    int total = 0;
    int bad   = 0;

    cache_arbiter #(.LINE_W(LW), .ADDR_W(AW)) dut (
        .clk         (clk),
        .rst         (rst),
        .i_read      (i_read),
        .i_address   (i_address),
        .i_rdata     (i_rdata),
        .i_resp      (i_resp),
        .d_read      (d_read),
        .d_write     (d_write),
        .d_address   (d_address),
        .d_wdata     (d_wdata),
        .d_rdata     (d_rdata),
        .d_resp      (d_resp),
        .mem_read    (mem_read),
        .mem_write   (mem_write),
        .mem_address (mem_address),
        .mem_wdata   (mem_wdata),
        .mem_rdata   (mem_rdata),
        .mem_resp    (mem_resp)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout required finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    function automatic logic [LW-1:0] rand_line();
        logic [LW-1:0] v;
        for (int k = 0; k < LW / 32; k++) v[k*32 +: 32] = $urandom;
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Transaction-level reference: who owns the port, whether the one-cycle
    // cooldown is pending, and what was captured at grant time.
    int            m_owner;     // -1 none, 0 I-cache, 1 D-cache
    bit            m_cool;
    bit            m_last_d;
    bit            m_wr;
    logic [AW-1:0] m_addr;
    logic [LW-1:0] m_wdata;
    int            m_icnt;
    int            m_dcnt;

    task automatic model_reset();
        m_owner  = -1;
        m_cool   = 0;
        m_last_d = 1;
        m_wr     = 0;
        m_addr   = '0;
        m_wdata  = '0;
        m_icnt   = 0;
        m_dcnt   = 0;
    endtask

    task automatic model_edge();
        int  win;
        bit  was_i;
        bit  was_d;
        bit  ir;
        bit  dr;
        win   = -1;
        was_i = (m_owner == 0);
        was_d = (m_owner == 1);
        ir    = i_read;
        dr    = d_read | d_write;
        if (m_owner >= 0) begin
            if (mem_resp) begin
                m_owner = -1;
                m_cool  = 1;
            end
        end else if (m_cool) begin
            m_cool = 0;
        end else begin
            if (ir && dr) win = m_last_d ? 0 : 1;
            else if (ir)  win = 0;
            else if (dr)  win = 1;
            if (win == 0) begin
                m_addr   = i_address;
                m_wr     = 0;
                m_last_d = 0;
            end else if (win == 1) begin
                m_addr   = d_address;
                m_wdata  = d_wdata;
                m_wr     = d_write;
                m_last_d = 1;
            end
            m_owner = win;
        end
        if (win == 0) m_icnt = 0;
        else if (ir && !was_i) m_icnt = (m_icnt < 65535) ? m_icnt + 1 : 65535;
        if (win == 1) m_dcnt = 0;
        else if (dr && !was_d) m_dcnt = (m_dcnt < 65535) ? m_dcnt + 1 : 65535;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst       = 1'b0;
        i_read    = 1'b0;
        d_read    = 1'b0;
        d_write   = 1'b0;
        mem_resp  = 1'b0;
        i_address = '0;
        d_address = '0;
        d_wdata   = '0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        model_reset();
    endtask

    typedef struct {
        logic          ir;
        logic          dw;
        logic          mr;
        logic          e_mr;
        logic          e_mw;
        logic [AW-1:0] e_addr;
        logic          e_ir;
        logic          e_dr;
        logic          e_wd;     // 1: mem_wdata must be the A5 pattern, 0: zero
    } vec_t;

    function automatic vec_t mk(input logic ir, input logic dw, input logic mr,
                                input logic e_mr, input logic e_mw, input logic [AW-1:0] e_addr,
                                input logic e_ir, input logic e_dr, input logic e_wd);
        vec_t v;
        v.ir = ir; v.dw = dw; v.mr = mr;
        v.e_mr = e_mr; v.e_mw = e_mw; v.e_addr = e_addr;
        v.e_ir = e_ir; v.e_dr = e_dr; v.e_wd = e_wd;
        return v;
    endfunction

    vec_t          tbl [16];
    logic [LW-1:0] a5;
    logic [LW-1:0] exp_wd;
    int            lat_cnt;
    int            max_i;
    int            max_d;
    int            order [$];
    bit            strobe;

    initial begin
        a5 = {(LW / 8){8'hA5}};
        // Tie: I at 0x1000 and D writeback at 0x2000 raised together, latency 4.
        tbl[0]  = mk(1, 1, 0,  0, 0, 32'h0000, 0, 0, 0);
        tbl[1]  = mk(1, 1, 0,  1, 0, 32'h1000, 0, 0, 0);
        tbl[2]  = mk(1, 1, 0,  1, 0, 32'h1000, 0, 0, 0);
        tbl[3]  = mk(1, 1, 0,  1, 0, 32'h1000, 0, 0, 0);
        tbl[4]  = mk(1, 1, 1,  1, 0, 32'h1000, 1, 0, 0);
        tbl[5]  = mk(0, 1, 0,  0, 0, 32'h1000, 0, 0, 0);
        tbl[6]  = mk(0, 1, 0,  0, 0, 32'h1000, 0, 0, 0);
        tbl[7]  = mk(0, 1, 0,  0, 1, 32'h2000, 0, 0, 1);
        tbl[8]  = mk(0, 1, 0,  0, 1, 32'h2000, 0, 0, 1);
        tbl[9]  = mk(0, 1, 0,  0, 1, 32'h2000, 0, 0, 1);
        tbl[10] = mk(0, 1, 1,  0, 1, 32'h2000, 0, 1, 1);
        tbl[11] = mk(0, 0, 0,  0, 0, 32'h2000, 0, 0, 1);
        tbl[12] = mk(0, 0, 1,  0, 0, 32'h2000, 0, 0, 1);  // stray resp in IDLE
        tbl[13] = mk(0, 0, 0,  0, 0, 32'h2000, 0, 0, 1);
        tbl[14] = mk(1, 0, 0,  0, 0, 32'h2000, 0, 0, 1);
        tbl[15] = mk(1, 0, 0,  1, 0, 32'h1000, 0, 0, 1);

        rst       = 1'b0;
        i_read    = 1'b1;
        i_address = 32'h5540;
        d_read    = 1'b0;
        d_write   = 1'b0;
        d_address = '0;
        d_wdata   = '0;
        mem_rdata = rand_line();
        mem_resp  = 1'b1;

        // Reset held with a pending request and a stray response.
        @(negedge clk);
        for (int c = 0; c < 3; c++) begin
            #1;
            check("rst mem_read",  LW'(mem_read),  LW'(0));
            check("rst mem_write", LW'(mem_write), LW'(0));
            check("rst i_resp",    LW'(i_resp),    LW'(0));
            check("rst d_resp",    LW'(d_resp),    LW'(0));
            check("rst i_wait_cnt", LW'(dut.i_wait_cnt), LW'(0));
            check("rst mem_wdata", mem_wdata, LW'(0));
            check("rst i_rdata",   i_rdata, mem_rdata);
            tick();
        end
        rst      = 1'b1;
        mem_resp = 1'b0;
        #1;
        check("post-rst idle mem_read", LW'(mem_read), LW'(0));
        tick();
        #1;
        check("post-rst grant mem_read", LW'(mem_read), LW'(1));
        check("post-rst grant addr", LW'(mem_address), LW'(32'h5540));

        // Table-driven tie / stray-response sequence.
        do_reset();
        i_address = 32'h1000;
        d_address = 32'h2000;
        d_wdata   = a5;
        for (int k = 0; k < 16; k++) begin
            i_read   = tbl[k].ir;
            d_write  = tbl[k].dw;
            mem_resp = tbl[k].mr;
            mem_rdata = rand_line();
            #1;
            exp_wd = tbl[k].e_wd ? a5 : '0;
            check($sformatf("row%0d mem_read", k),  LW'(mem_read),    LW'(tbl[k].e_mr));
            check($sformatf("row%0d mem_write", k), LW'(mem_write),   LW'(tbl[k].e_mw));
            check($sformatf("row%0d mem_address", k), LW'(mem_address), LW'(tbl[k].e_addr));
            check($sformatf("row%0d i_resp", k),    LW'(i_resp),      LW'(tbl[k].e_ir));
            check($sformatf("row%0d d_resp", k),    LW'(d_resp),      LW'(tbl[k].e_dr));
            check($sformatf("row%0d mem_wdata", k), mem_wdata,        exp_wd);
            check($sformatf("row%0d d_rdata", k),   d_rdata,          mem_rdata);
            tick();
        end

        // Address change mid-transaction, with I pending and a resp owned by D.
        do_reset();
        d_read    = 1'b1;
        d_address = 32'h3000;
        tick();
        i_read    = 1'b1;
        i_address = 32'h8000;
        d_address = 32'h4000;
        #1;
        check("achg mem_read", LW'(mem_read), LW'(1));
        check("achg addr1", LW'(mem_address), LW'(32'h3000));
        tick();
        #1;
        check("achg addr2", LW'(mem_address), LW'(32'h3000));
        check("achg i_resp early", LW'(i_resp), LW'(0));
        tick();
        mem_resp  = 1'b1;
        mem_rdata = rand_line();
        #1;
        check("achg d_resp", LW'(d_resp), LW'(1));
        check("achg i_resp", LW'(i_resp), LW'(0));
        check("achg addr3", LW'(mem_address), LW'(32'h3000));
        check("achg d_rdata", d_rdata, mem_rdata);
        check("achg i_wait_cnt", LW'(dut.i_wait_cnt), LW'(2));
        check("achg d_wait_cnt", LW'(dut.d_wait_cnt), LW'(0));
        tick();
        mem_resp = 1'b0;
        d_read   = 1'b0;
        #1;
        check("achg recover rd", LW'(mem_read | mem_write), LW'(0));

        // Abort: reset asserted mid-cycle during SERVE_D.
        do_reset();
        d_write   = 1'b1;
        d_address = 32'h6000;
        d_wdata   = a5;
        tick();
        i_read    = 1'b1;
        i_address = 32'h7000;
        #1;
        check("abort mem_write", LW'(mem_write), LW'(1));
        check("abort wdata", mem_wdata, a5);
        #2;
        rst      = 1'b0;
        mem_resp = 1'b1;
        #1;
        check("abort strobes drop", LW'(mem_read | mem_write), LW'(0));
        check("abort no d_resp", LW'(d_resp), LW'(0));
        @(negedge clk);
        d_write  = 1'b0;
        mem_resp = 1'b0;
        rst      = 1'b1;
        #1;
        check("abort idle", LW'(mem_read | mem_write), LW'(0));
        tick();
        #1;
        check("abort i grant rd", LW'(mem_read), LW'(1));
        check("abort i grant wr", LW'(mem_write), LW'(0));
        check("abort i grant addr", LW'(mem_address), LW'(32'h7000));

        // Fairness: both held continuously, fixed memory latency LAT.
        do_reset();
        i_read    = 1'b1;
        i_address = 32'hA000;
        d_read    = 1'b1;
        d_address = 32'hB000;
        lat_cnt   = 0;
        max_i     = 0;
        max_d     = 0;
        order.delete();
        for (int c = 0; c < 200 && order.size() < 6; c++) begin
            strobe = mem_read | mem_write;
            lat_cnt = strobe ? lat_cnt + 1 : 0;
            mem_resp = strobe && (lat_cnt == LAT);
            #1;
            if (i_resp) order.push_back(0);
            if (d_resp) order.push_back(1);
            if (int'(dut.i_wait_cnt) > max_i) max_i = int'(dut.i_wait_cnt);
            if (int'(dut.d_wait_cnt) > max_d) max_d = int'(dut.d_wait_cnt);
            tick();
        end
        mem_resp = 1'b0;
        check("fair count", LW'(order.size()), LW'(6));
        for (int k = 0; k < order.size(); k++)
            check($sformatf("fair order%0d", k), LW'(order[k]), LW'(k % 2));
        check("fair max_i bound", LW'(max_i <= LAT + 4), LW'(1));
        check("fair max_d bound", LW'(max_d <= LAT + 4), LW'(1));

        // Randomized traffic against the reference model.
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 3) == 0) i_read  = ~i_read;
            if ($urandom_range(0, 5) == 0) d_read  = ~d_read;
            if ($urandom_range(0, 5) == 0) d_write = ~d_write;
            if ($urandom_range(0, 2) == 0) i_address = $urandom;
            if ($urandom_range(0, 2) == 0) d_address = $urandom;
            d_wdata   = rand_line();
            mem_rdata = rand_line();
            mem_resp  = ($urandom_range(0, 2) == 0);
            #1;
            check("rnd mem_read",  LW'(mem_read),
                  LW'((m_owner == 0) || (m_owner == 1 && !m_wr)));
            check("rnd mem_write", LW'(mem_write), LW'(m_owner == 1 && m_wr));
            check("rnd mem_address", LW'(mem_address), LW'(m_addr));
            check("rnd mem_wdata", mem_wdata, m_wdata);
            check("rnd i_resp", LW'(i_resp), LW'(m_owner == 0 && mem_resp));
            check("rnd d_resp", LW'(d_resp), LW'(m_owner == 1 && mem_resp));
            check("rnd i_rdata", i_rdata, mem_rdata);
            check("rnd i_wait_cnt", LW'(dut.i_wait_cnt), LW'(m_icnt));
            check("rnd d_wait_cnt", LW'(dut.d_wait_cnt), LW'(m_dcnt));
            model_edge();
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
